bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the iterative double-dabble method (add-3, then shift), one input bit per clock.
- Successor to the combinational converter. It trades latency for area and gives wide score/timer values a start/done handshake.
- Sits between game-state counters and the seven-segment/VGA digit renderers.

---
 rtl/bin_to_bcd_seq.sv | 168 ++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using the iterative double-dabble
// method. One input bit is consumed per CLK_I cycle. Every cycle, each working
// digit that is 5 or more gets 3 added. Then the whole {BCD, binary} register
// pair shifts left by one bit. After SIZE_I shifts the working BCD register
// holds the result. That value is copied to BCD_O and DONE pulses for one cycle.
//
// Intended to sit between wide game-state counters (score, timers) and the
// digit renderers. It trades SIZE_I cycles of latency for a small datapath.
//
// Parameters:
//   SIZE_I   binary input width (>= 4)
//   SIZE_O   BCD output width, a multiple of 4, large enough for 2^SIZE_I-1
//
// Ports:
//   CLK_I    in   clock, rising edge
//   RST      in   asynchronous, active-high reset
//   START    in   conversion request, sampled only while BUSY=0
//   BIN_I    in   binary value, captured on the edge that accepts START
//   BUSY     out  high while a conversion is in progress
//   DONE     out  one-cycle pulse: BCD_O has just been updated
//   BCD_O    out  packed BCD result, digit 0 in [3:0], held until next result
//   BLANK_O  out  (only with BCD_BLANK_EN) leading-zero blanking mask, one
//                 bit per digit. Bit d is set when digit d and every higher
//                 digit are zero. Bit 0 is never set.
//
// Optional feature macro: BCD_BLANK_EN
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int SIZE_I = 16,
    parameter int SIZE_O = (SIZE_I + (SIZE_I + 4) / 5 + 3) / 4 * 4
) (
    input  logic                CLK_I,
    input  logic                RST,
    input  logic                START,
    input  logic [SIZE_I-1:0]   BIN_I,
    output logic                BUSY,
    output logic                DONE,
    output logic [SIZE_O-1:0]   BCD_O
`ifdef BCD_BLANK_EN
    ,
    output logic [SIZE_O/4-1:0] BLANK_O
`endif
);

    localparam int NDIG  = SIZE_O / 4;
    localparam int CNT_W = $clog2(SIZE_I + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t              state_q;
    logic [SIZE_I-1:0]   shift_q;
    logic [SIZE_O-1:0]   work_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SIZE_O-1:0]   bcd_q;
    logic                busy_q;
    logic                done_q;

    logic [SIZE_O-1:0]   bcd_adj;
    logic [SIZE_O-1:0]   work_d;
    logic [SIZE_I-1:0]   shift_d;

    // -----------------------------------------------------------------------
    // One double-dabble step: add-3 per digit, then shift left by one.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        bcd_adj = '0;
        for (int d = 0; d < NDIG; d++) begin
            // Digits are adjusted independently; no carry crosses a digit
            // boundary because an adjusted digit never exceeds 4'hC.
            if (work_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
            end else begin
                bcd_adj[4*d +: 4] = work_q[4*d +: 4];
            end
        end
        // The binary MSB enters BCD bit 0. The adjusted top bit falls off the
        // end. It is always zero because SIZE_O is large enough for the result.
        work_d  = SIZE_O'({bcd_adj, shift_q[SIZE_I-1]});
        shift_d = {shift_q[SIZE_I-2:0], 1'b0};
    end

`ifdef BCD_BLANK_EN
    logic [NDIG-1:0] blank_q;
    logic [NDIG-1:0] blank_d;
    logic            zero_above;

    // Scan from the top digit down. A digit is blanked while it and everything
    // above it are zero. Digit 0 always stays visible, so 0 renders as "0".
    always_comb begin
        blank_d    = '0;
        zero_above = 1'b1;
        for (int d = NDIG - 1; d >= 0; d--) begin
            zero_above = zero_above & (work_d[4*d +: 4] == 4'd0);
            blank_d[d] = zero_above;
        end
        blank_d[0] = 1'b0;
    end

    assign BLANK_O = blank_q;
`endif

    // -----------------------------------------------------------------------
    // Control FSM and all registered state.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_I or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        shift_q <= BIN_I;
                        work_q  <= '0;
                        cnt_q   <= CNT_W'(SIZE_I);
                        busy_q  <= 1'b1;
                        state_q <= CONVERT;
                    end
                end

                CONVERT: begin
                    work_q  <= work_d;
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    // On the last shift the post-shift value is published
                    // directly, so BCD_O never shows intermediate values.
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= work_d;
`ifdef BCD_BLANK_EN
                        blank_q <= blank_d;
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign BCD_O = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Self-checking bench for bin_to_bcd_seq. It has a 16-bit instance (SIZE_O=20)
// and an 8-bit instance (SIZE_O=12). Expected values come from a reference
// model that extracts decimal digits with / and %. The expected blanking mask
// comes from comparing the value against powers of ten.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;

    logic        start16;
    logic [15:0] bin16;
    logic        busy16;
    logic        done16;
    logic [19:0] bcd16;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [11:0] bcd8;

`ifdef BCD_BLANK_EN
    logic [4:0]  blank16;
    logic [2:0]  blank8;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    bin_to_bcd_seq #(.SIZE_I(16)) u_dut16 (
        .CLK_I   (clk),
        .RST     (rst),
        .START   (start16),
        .BIN_I   (bin16),
        .BUSY    (busy16),
        .DONE    (done16),
        .BCD_O   (bcd16)
`ifdef BCD_BLANK_EN
        ,
        .BLANK_O (blank16)
`endif
    );

    bin_to_bcd_seq #(.SIZE_I(8)) u_dut8 (
        .CLK_I   (clk),
        .RST     (rst),
        .START   (start8),
        .BIN_I   (bin8),
        .BUSY    (busy8),
        .DONE    (done8),
        .BCD_O   (bcd8)
`ifdef BCD_BLANK_EN
        ,
        .BLANK_O (blank8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic logic [19:0] model_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_blank(input int unsigned v, input int ndig);
        logic [4:0] b;
        int unsigned p;
        b = '0;
        p = 1;
        for (int d = 1; d < ndig; d++) begin
            p = p * 10;
            b[d] = (v < p);
        end
        return b;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------- 16-bit conversion
    task automatic convert16(input logic [15:0] v, input string tag);
        logic [19:0] prev;
        logic [19:0] exp_bcd;
        int          cycles;
        bit          busy_ok;
        bit          hold_ok;
        prev    = bcd16;
        exp_bcd = model_bcd(v);
        start16 = 1'b1;
        bin16   = v;
        tick();                         // edge k accepts START
        start16 = 1'b0;
        bin16   = 16'($urandom);        // changes during CONVERT must not matter
        tests_run++;
        if (busy16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_after_start: got %b expected 1", tag, busy16);
        end
        cycles  = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (done16 !== 1'b1 && cycles < 100) begin
            if (busy16 !== 1'b1) busy_ok = 1'b0;
            if (bcd16 !== prev)  hold_ok = 1'b0;
            tick();
            cycles++;
        end
        tests_run++;
        if (cycles != 16 || !busy_ok || !hold_ok) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d cycles busy_ok=%b hold_ok=%b expected 16 1 1",
                     tag, cycles, busy_ok, hold_ok);
        end
        tests_run++;
        if (bcd16 !== exp_bcd || busy16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s result: got bcd=%h busy=%b expected bcd=%h busy=0",
                     tag, bcd16, busy16, exp_bcd);
        end
`ifdef BCD_BLANK_EN
        tests_run++;
        if (blank16 !== model_blank(v, 5)) begin
            tests_failed++;
            $display("FAIL %s blank: got %b expected %b", tag, blank16, model_blank(v, 5));
        end
`endif
        tick();
        tests_run++;
        if (done16 !== 1'b0 || bcd16 !== exp_bcd) begin
            tests_failed++;
            $display("FAIL %s done_pulse: got done=%b bcd=%h expected done=0 bcd=%h",
                     tag, done16, bcd16, exp_bcd);
        end
    endtask

    // -------------------------------------------------- 8-bit conversion
    task automatic convert8(input logic [7:0] v, input string tag);
        logic [19:0] full;
        logic [11:0] exp_bcd;
        logic [4:0]  bfull;
        int          cycles;
        full    = model_bcd(v);
        exp_bcd = full[11:0];
        bfull   = model_blank(v, 3);
        start8  = 1'b1;
        bin8    = v;
        tick();
        start8  = 1'b0;
        bin8    = 8'($urandom);
        cycles  = 0;
        while (done8 !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        tests_run++;
        if (cycles != 8 || bcd8 !== exp_bcd || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got cycles=%0d bcd=%h busy=%b expected cycles=8 bcd=%h busy=0",
                     tag, cycles, bcd8, busy8, exp_bcd);
        end
`ifdef BCD_BLANK_EN
        tests_run++;
        if (blank8 !== bfull[2:0]) begin
            tests_failed++;
            $display("FAIL %s blank: got %b expected %b", tag, blank8, bfull[2:0]);
        end
`endif
    endtask

    // ---------------------------------------------------------- scenarios
    task automatic test_reset();
        rst     = 1'b1;
        start16 = 1'b0;
        bin16   = '0;
        start8  = 1'b0;
        bin8    = '0;
        repeat (3) tick();
        tests_run++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || bcd16 !== 20'h0 ||
            busy8 !== 1'b0 || done8 !== 1'b0 || bcd8 !== 12'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b bcd=%h / %b %b %h expected all 0",
                     busy16, done16, bcd16, busy8, done8, bcd8);
        end
`ifdef BCD_BLANK_EN
        tests_run++;
        if (blank16 !== 5'b0 || blank8 !== 3'b0) begin
            tests_failed++;
            $display("FAIL reset_blank: got %b %b expected 0 0", blank16, blank8);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_corners();
        convert16(16'd0,    "zero");
        convert16(16'hFFFF, "max");
        tests_run++;
        if (bcd16 !== 20'h65535) begin
            tests_failed++;
            $display("FAIL max_literal: got %h expected 65535", bcd16);
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        int done_at;
        start16  = 1'b1;
        bin16    = 16'd1234;
        tick();                         // edge k
        done_cnt = 0;
        done_at  = -1;
        for (int c = 1; c <= 30; c++) begin
            start16 = (c == 3 || c == 8);
            bin16   = 16'd9999;
            tick();                     // edge k+c
            if (done16 === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
                tests_run++;
                if (bcd16 !== 20'h01234) begin
                    tests_failed++;
                    $display("FAIL ignore_result: got %h expected 01234", bcd16);
                end
`ifdef BCD_BLANK_EN
                tests_run++;
                if (blank16 !== 5'b10000) begin
                    tests_failed++;
                    $display("FAIL ignore_blank: got %b expected 10000", blank16);
                end
`endif
            end
        end
        start16 = 1'b0;
        tests_run++;
        if (done_cnt != 1 || done_at != 16) begin
            tests_failed++;
            $display("FAIL ignore_done_count: got %0d pulses first at %0d expected 1 at 16",
                     done_cnt, done_at);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cycles;
        start16 = 1'b1;
        bin16   = 16'd42;
        tick();                         // edge k
        bin16   = 16'd100;              // captured by the restart at k+17
        cycles  = 0;
        while (done16 !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        tests_run++;
        if (cycles != 16 || bcd16 !== 20'h00042) begin
            tests_failed++;
            $display("FAIL b2b_first: got cycles=%0d bcd=%h expected 16 00042", cycles, bcd16);
        end
        tick();                         // edge k+17 restarts
        tests_run++;
        if (done16 !== 1'b0 || busy16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_restart: got done=%b busy=%b expected 0 1", done16, busy16);
        end
        cycles = 0;
        while (done16 !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        start16 = 1'b0;
        tests_run++;
        if (cycles != 16 || bcd16 !== 20'h00100) begin
            tests_failed++;
            $display("FAIL b2b_second: got cycles=%0d bcd=%h expected 16 00100", cycles, bcd16);
        end
        tick();
        tests_run++;
        if (done16 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done_twice: got done=%b expected 0", done16);
        end
    endtask

    task automatic test_reset_abort();
        bit quiet;
        convert16(16'd500, "pre_abort");
        tests_run++;
        if (bcd16 !== 20'h00500) begin
            tests_failed++;
            $display("FAIL pre_abort_literal: got %h expected 00500", bcd16);
        end
        start16 = 1'b1;
        bin16   = 16'd777;
        tick();                         // edge k
        start16 = 1'b0;
        repeat (6) tick();              // after edge k+6
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || bcd16 !== 20'h0) begin
            tests_failed++;
            $display("FAIL abort_async: got busy=%b done=%b bcd=%h expected 0 0 0",
                     busy16, done16, bcd16);
        end
        tick();
        rst   = 1'b0;
        quiet = 1'b1;
        repeat (25) begin
            tick();
            if (done16 !== 1'b0 || busy16 !== 1'b0 || bcd16 !== 20'h0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL abort_quiet: got done/busy/bcd activity expected none (bcd=%h)", bcd16);
        end
    endtask

    task automatic test_size8();
        convert8(8'd255, "s8_max");
        tests_run++;
        if (bcd8 !== 12'h255) begin
            tests_failed++;
            $display("FAIL s8_max_literal: got %h expected 255", bcd8);
        end
        convert8(8'd9, "s8_nine");
        tests_run++;
        if (bcd8 !== 12'h009) begin
            tests_failed++;
            $display("FAIL s8_nine_literal: got %h expected 009", bcd8);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            convert16(16'($urandom), "rand16");
        end
        for (int i = 0; i < 10; i++) begin
            convert8(8'($urandom), "rand8");
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_size8();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
